mx_block_acc: RTL and testbench
===============================

Name: mx_block_acc

Overview:
- Sits directly downstream of the MX floating-point dot-product stage.
- Consumes one signed fixed-point partial dot product per MX block, together with the two shared E8M0 block scales.
- Aligns each partial product to a running common exponent and accumulates over a vector of blocks.
- Emits one scaled fixed-point result per vector on a valid/ready interface.

Parameters:
- dp_width, 73, width of incoming partial dot product; equals dot-stage out_width for e5m2, k=32.
- max_blocks, 8, maximum blocks per vector; the beat that reaches this count is forced-last.
- frac_bits, 8, fractional guard bits appended below the dp LSB to keep precision on right shifts.
- acc_width, dp_width+frac_bits+$clog2(max_blocks)+1, accumulator width; derived, never overridden.
- cnt_width, $clog2(max_blocks+1), block counter width; derived.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_dp  in  dp_width  signed partial dot product.
- i_scale_a  in  8  E8M0 scale of operand A block; 0xFF means NaN.
- i_scale_b  in  8  E8M0 scale of operand B block; 0xFF means NaN.
- i_last  in  1  final block of the vector.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_acc  out  acc_width  signed accumulated mantissa; LSB weight 2^-frac_bits of dp LSB.
- o_exp  out  9  unsigned combined exponent scale_a+scale_b, biased by 254.
- o_nblk  out  cnt_width  number of blocks accumulated.
- o_nan  out  1  a NaN scale occurred in this vector.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state ACC, empty=1, acc=0, acc_exp=0, count=0, nan=0. o_valid=0, o_acc=0, o_exp=0, o_nblk=0, o_nan=0, o_ready=1.
- States:
  - ACC: o_ready=1, o_valid=0.
  - OUT: o_ready=0, o_valid=1, all outputs held stable.
- Beat acceptance: a beat is accepted when i_valid && o_ready. Let e = i_scale_a + i_scale_b (9-bit) and x = sign-extend(i_dp) << frac_bits.
- NaN beat (either scale = 0xFF): set nan; count++; acc and acc_exp unchanged.
- First non-NaN beat (empty=1): acc = x; acc_exp = e; empty = 0.
- e > acc_exp: acc = (acc >>> (e - acc_exp)) + x; acc_exp = e.
- e <= acc_exp: acc = acc + (x >>> (acc_exp - e)).
- Shift rules: all shifts are arithmetic (floor). Any shift amount >= acc_width yields pure sign fill (0 or -1). Shift amount range is 0..508.
- Counter: count increments on every accepted beat.
- Termination: if i_last, or count+1 == max_blocks, move to OUT at the next edge. Outputs are registered, so latency from the last accepted beat to o_valid is 1 cycle.
- Overflow: cannot occur; acc_width covers max_blocks aligned addends. No saturation logic.
- Output handshake: in OUT, o_valid && i_ready returns to ACC and clears acc, acc_exp, count, nan, and empty=1. Exactly one bubble cycle per vector; there is no accept in the handoff cycle.
- All-NaN vector: o_acc=0, o_exp=0, o_nan=1.
- i_valid while in OUT: ignored, because o_ready=0; upstream must hold the beat.
- Reset mid-vector or mid-OUT: immediately returns to reset values; a pending result is discarded.

Decomposition:
- Shared package mx_pkg holds:
  - E8M0_NAN = 8'hFF;
  - EXP_BIAS2 = 254;
  - typedef e8m0_t (logic [7:0]);
  - typedef cexp_t (logic [8:0]).
- One natural sub-module: mx_align_shift. It is a combinational signed arithmetic right shift with sign-fill clamp, parameterised on width, instantiated once. Operand select muxes feed either acc or x into it.

Test Plan:
1. Single block: dp=100, scales 127/127, i_last -> next cycle o_valid=1, o_acc=25600, o_exp=254, o_nblk=1, o_nan=0.
2. Same-exponent sum and align-up:
   - dp=5, -3 at scales 127/127, last -> o_acc=512.
   - dp=4 at 127/127, then dp=4 at 128/128, last -> o_acc=1280, o_exp=256.
3. Align-down with floor and sign-fill clamp:
   - dp=1 at 128/128, then dp=-1 at 123/123, last -> o_acc=255, o_exp=256.
   - Then dp=-1 at 0/0 after dp=2 at 127/127 -> o_acc=511 (shift 254 gives -1).
4. NaN and backpressure:
   - 3 beats, beat 2 scale_a=0xFF, last on beat 3 -> o_nan=1, o_nblk=3, acc = sum of beats 1 and 3 only.
   - Hold i_ready=0 for 5 cycles: outputs stable, o_ready=0.
   - Assert i_ready: next cycle o_ready=1 and a new vector is accepted.
5. Forced-last: 8 beats of dp=1 at 127/127 with i_last=0 -> o_valid after beat 8, o_nblk=8, o_acc=2048.
6. Reset mid-vector: 2 beats accepted, pulse i_rst_n low asynchronously -> o_valid=0, o_ready=1, and the next single-beat vector dp=7 yields o_acc=1792, o_nblk=1.

Source files
------------

// File: rtl/mx_pkg.sv
// mx_pkg: shared MX scale types and constants.
package mx_pkg;
    typedef logic [7:0] e8m0_t;
    typedef logic [8:0] cexp_t;
    localparam e8m0_t E8M0_NAN  = 8'hFF;
    localparam cexp_t EXP_BIAS2 = 9'd254;
endpackage

// File: rtl/mx_align_shift.sv
// mx_align_shift: signed arithmetic right shift, clamped to pure sign fill for oversized amounts.
module mx_align_shift
    import mx_pkg::*;
#(
    parameter int W = 85
) (
    input  logic [W-1:0] in_i,
    input  cexp_t        sh_i,
    output logic [W-1:0] out_o
);
    assign out_o = (int'(sh_i) >= W) ? {W{in_i[W-1]}} : W'($signed(in_i) >>> sh_i);
endmodule

// File: rtl/mx_block_acc.sv
// mx_block_acc: aligns per-block MX partial dot products to a running exponent
// and accumulates them into one scaled fixed-point result per vector.
module mx_block_acc
    import mx_pkg::*;
#(
    parameter  int dp_width   = 73,
    parameter  int max_blocks = 8,
    parameter  int frac_bits  = 8,
    localparam int acc_width  = dp_width + frac_bits + $clog2(max_blocks) + 1,
    localparam int cnt_width  = $clog2(max_blocks + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [dp_width-1:0]  i_dp,
    input  e8m0_t                i_scale_a,
    input  e8m0_t                i_scale_b,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [acc_width-1:0] o_acc,
    output cexp_t                o_exp,
    output logic [cnt_width-1:0] o_nblk,
    output logic                 o_nan
);
    typedef enum logic {ACC, OUT} state_t;

    state_t                 state_q;
    logic [acc_width-1:0]   acc_q, acc_d, x, sh_in, sh_out;
    cexp_t                  exp_q, exp_d, e, sh_amt;
    logic [cnt_width-1:0]   cnt_q;
    logic                   empty_q, nan_q, nan_beat, up, done;

    assign nan_beat = i_scale_a == E8M0_NAN || i_scale_b == E8M0_NAN;
    assign e        = {1'b0, i_scale_a} + {1'b0, i_scale_b};
    assign x        = {{(acc_width - dp_width){i_dp[dp_width-1]}}, i_dp} << frac_bits;
    // Only the operand with the smaller exponent is ever shifted, so one shifter suffices.
    assign up       = e > exp_q;
    assign sh_in    = up ? acc_q : x;
    assign sh_amt   = up ? e - exp_q : exp_q - e;
    assign done     = i_last || cnt_q == cnt_width'(max_blocks - 1);

    mx_align_shift #(.W(acc_width)) u_shift (
        .in_i  (sh_in),
        .sh_i  (sh_amt),
        .out_o (sh_out)
    );

    always_comb begin
        acc_d = empty_q ? x : up ? sh_out + x : acc_q + sh_out;
        exp_d = (empty_q || up) ? e : exp_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            nan_q   <= 1'b0;
            empty_q <= 1'b1;
        end else if (state_q == OUT) begin
            if (i_ready) begin
                state_q <= ACC;
                acc_q   <= '0;
                exp_q   <= '0;
                cnt_q   <= '0;
                nan_q   <= 1'b0;
                empty_q <= 1'b1;
            end
        end else if (i_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (nan_beat) begin
                nan_q <= 1'b1;
            end else begin
                acc_q   <= acc_d;
                exp_q   <= exp_d;
                empty_q <= 1'b0;
            end
            if (done) state_q <= OUT;
        end
    end

    assign o_ready = state_q == ACC;
    assign o_valid = state_q == OUT;
    assign o_acc   = acc_q;
    assign o_exp   = exp_q;
    assign o_nblk  = cnt_q;
    assign o_nan   = nan_q;
endmodule

// File: tb/tb_mx_block_acc.sv
// tb_mx_block_acc: directed plus randomized vectors checked against a
// per-vector reference that replays the beat list with exact integer arithmetic.
module tb_mx_block_acc;
    import mx_pkg::*;

    localparam int DPW = 73;
    localparam int AW  = 85;
    localparam int CW  = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b0;
    logic [DPW-1:0] i_dp = '0;
    e8m0_t sa = '0, sb = '0;
    logic o_ready, o_valid, o_nan;
    logic [AW-1:0] o_acc;
    cexp_t o_exp;
    logic [CW-1:0] o_nblk;

    int n_cmp = 0, n_bad = 0;
    logic signed [DPW-1:0] q_dp[$];
    e8m0_t q_a[$], q_b[$];

    always #5 clk = ~clk;

    mx_block_acc dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_dp(i_dp), .i_scale_a(sa), .i_scale_b(sb), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_acc(o_acc), .o_exp(o_exp),
        .o_nblk(o_nblk), .o_nan(o_nan)
    );

    task automatic check(input string tag, input logic signed [95:0] got, input logic signed [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [AW-1:0] floor_shr(input logic signed [AW-1:0] v, input int n);
        if (n >= AW) return v < 0 ? -1 : 0;
        return v >>> n;
    endfunction

    function automatic void model(output logic signed [AW-1:0] acc, output cexp_t ex, output logic nan);
        logic signed [AW-1:0] x;
        int e;
        bit empty = 1;
        acc = '0; ex = '0; nan = 1'b0;
        foreach (q_dp[i]) begin
            if (q_a[i] == 8'hFF || q_b[i] == 8'hFF) begin
                nan = 1'b1;
                continue;
            end
            e = int'(q_a[i]) + int'(q_b[i]);
            x = q_dp[i];
            x = x * 256;
            if (empty) begin
                acc = x; ex = cexp_t'(e); empty = 0;
            end else if (e > int'(ex)) begin
                acc = floor_shr(acc, e - int'(ex)) + x; ex = cexp_t'(e);
            end else begin
                acc = acc + floor_shr(x, int'(ex) - e);
            end
        end
    endfunction

    task automatic put(input logic signed [DPW-1:0] dp, input e8m0_t a, input e8m0_t b, input logic last);
        int n = 0;
        i_valid = 1'b1; i_dp = dp; sa = a; sb = b; i_last = last;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("put_ready", o_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
        q_dp.push_back(dp); q_a.push_back(a); q_b.push_back(b);
    endtask

    task automatic expect_out(input string tag);
        logic signed [AW-1:0] m_acc;
        cexp_t m_exp;
        logic m_nan;
        int n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_ready"}, o_ready, 0);
        model(m_acc, m_exp, m_nan);
        check({tag, "_acc"}, $signed(o_acc), m_acc);
        check({tag, "_exp"}, o_exp, m_exp);
        check({tag, "_nblk"}, o_nblk, q_dp.size());
        check({tag, "_nan"}, o_nan, m_nan);
        q_dp.delete(); q_a.delete(); q_b.delete();
    endtask

    task automatic release_out();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    initial begin
        logic [95:0] r;
        e8m0_t ra, rb;
        int len;
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_acc", $signed(o_acc), 0);
        check("rst_exp", o_exp, 0);
        check("rst_nblk", o_nblk, 0);
        check("rst_nan", o_nan, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        put(100, 127, 127, 1);
        expect_out("single");
        check("single_acc_c", $signed(o_acc), 25600);
        check("single_exp_c", o_exp, EXP_BIAS2);
        release_out();

        put(5, 127, 127, 0); put(-3, 127, 127, 1);
        expect_out("same_exp");
        check("same_exp_acc_c", $signed(o_acc), 512);
        release_out();

        put(4, 127, 127, 0); put(4, 128, 128, 1);
        expect_out("align_up");
        check("align_up_acc_c", $signed(o_acc), 1280);
        check("align_up_exp_c", o_exp, 256);
        release_out();

        put(1, 128, 128, 0); put(-1, 123, 123, 1);
        expect_out("floor");
        check("floor_acc_c", $signed(o_acc), 255);
        release_out();

        put(2, 127, 127, 0); put(-1, 0, 0, 1);
        expect_out("clamp");
        check("clamp_acc_c", $signed(o_acc), 511);
        release_out();

        put(5, 8'hFF, 8'hFF, 1);
        expect_out("all_nan");
        check("all_nan_acc_c", $signed(o_acc), 0);
        release_out();

        put(10, 127, 127, 0); put(20, 8'hFF, 127, 0); put(30, 127, 127, 1);
        expect_out("nan");
        check("nan_acc_c", $signed(o_acc), 10240);
        check("nan_nblk_c", o_nblk, 3);
        i_valid = 1'b1; i_dp = 7; sa = 127; sb = 127; i_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", o_valid, 1);
            check("bp_ready", o_ready, 0);
            check("bp_acc", $signed(o_acc), 10240);
            check("bp_nblk", o_nblk, 3);
        end
        release_out();
        check("handoff_ready", o_ready, 1);
        check("handoff_valid", o_valid, 0);
        put(7, 127, 127, 1);
        expect_out("held");
        check("held_acc_c", $signed(o_acc), 1792);
        release_out();

        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("forced_pre_valid", o_valid, 0);
            put(1, 127, 127, 0);
        end
        expect_out("forced");
        check("forced_nblk_c", o_nblk, 8);
        check("forced_acc_c", $signed(o_acc), 2048);
        release_out();

        put(3, 127, 127, 0); put(9, 130, 120, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_ready", o_ready, 1);
        check("arst_acc", $signed(o_acc), 0);
        check("arst_nblk", o_nblk, 0);
        q_dp.delete(); q_a.delete(); q_b.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        put(7, 127, 127, 1);
        expect_out("post_rst");
        check("post_rst_acc_c", $signed(o_acc), 1792);
        release_out();

        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                r = {$urandom, $urandom, $urandom};
                case ($urandom_range(0, 9))
                    0: begin ra = 8'hFF; rb = 8'($urandom_range(0, 254)); end
                    1: begin ra = 8'($urandom_range(0, 254)); rb = 8'($urandom_range(0, 254)); end
                    default: begin ra = 8'($urandom_range(120, 135)); rb = 8'($urandom_range(120, 135)); end
                endcase
                put(r[DPW-1:0], ra, rb, (k == len - 1) && (len < 8 || $urandom_range(0, 1) == 1));
            end
            expect_out("rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_out();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
